// File: rtl/hex_page_scroller.sv
// Purpose : latch a 128-bit AES word and show one 32-bit quarter as eight hex nibbles,
//           paged by two debounced, synchronized raw pushbuttons.
// Latency : Load -> Page/Valid same edge, Hex_Nibbles +1 edge; button -> Page at edge
//           DEBOUNCE_CYCLES+2, Hex_Nibbles at DEBOUNCE_CYCLES+3. No backpressure (free-running sink).
//
// Ports:
//   Clk, Reset_n        clock (rising edge) and asynchronous active-low reset
//   Load, Data_In       single-cycle capture strobe and the 128-bit word (bit 127 = MSB)
//   Btn_Next_n/_Prev_n  raw active-low pushbuttons (asynchronous to Clk)
//   Hex_Nibbles         registered 32-bit window, [31:28] leftmost digit
//   Page                current quarter, 0 = bits 127:96 ... 3 = bits 31:0
//   Valid               a word has been captured since reset
module hex_page_scroller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         Load,
   input  logic [127:0] Data_In,
   input  logic         Btn_Next_n,
   input  logic         Btn_Prev_n,
   output logic [31:0]  Hex_Nibbles,
   output logic [1:0]   Page,
   output logic         Valid
);

   // Terminal count: the counter reaches this value after DEBOUNCE_CYCLES-1 differing
   // cycles, so the flip happens on the DEBOUNCE_CYCLES-th consecutive differing cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0 = Next button, bit 1 = Prev button.
   logic [1:0]       btn_raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       db;        // debounced level, 1 = released
   logic [1:0]       db_d;      // debounced level one cycle ago, for edge detect
   logic [CNT_W-1:0] cnt [2];
   logic [1:0]       press;
   logic [127:0]     capture;

   assign btn_raw = {Btn_Prev_n, Btn_Next_n};

   // Two-flop synchronizer plus debounce counter per button.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
         db    <= 2'b11;
         db_d  <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         db_d  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= ~db[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // One event per debounced falling edge; a held button stays low and cannot re-fire.
   assign press = db_d & ~db;

   // Capture, page and valid state. Load wins over any press on the same edge; opposing
   // presses on the same edge cancel.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         capture <= '0;
         Page    <= 2'd0;
         Valid   <= 1'b0;
      end else if (Load) begin
         capture <= Data_In;
         Page    <= 2'd0;
         Valid   <= 1'b1;
      end else if (Valid && (press[0] != press[1])) begin
         if (press[0]) begin
            Page <= Page + 2'd1;
         end else begin
            Page <= Page - 2'd1;
         end
      end
   end

   // Window register, one cycle behind Page/capture.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Hex_Nibbles <= '0;
      end else begin
         case (Page)
            2'd0:    Hex_Nibbles <= capture[127:96];
            2'd1:    Hex_Nibbles <= capture[95:64];
            2'd2:    Hex_Nibbles <= capture[63:32];
            default: Hex_Nibbles <= capture[31:0];
         endcase
      end
   end

endmodule

// File: tb/tb_hex_page_scroller.sv
module tb_hex_page_scroller;

   localparam int D = 4;
   localparam logic [127:0] K = 128'h0123456789ABCDEF_FEDCBA9876543210;

   logic         Clk = 1'b0;
   logic         Reset_n;
   logic         Load;
   logic [127:0] Data_In;
   logic         Btn_Next_n;
   logic         Btn_Prev_n;
   logic [31:0]  Hex_Nibbles;
   logic [1:0]   Page;
   logic         Valid;

   int n_checks = 0;
   int n_fail   = 0;

   hex_page_scroller #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .Data_In(Data_In),
      .Btn_Next_n(Btn_Next_n), .Btn_Prev_n(Btn_Prev_n),
      .Hex_Nibbles(Hex_Nibbles), .Page(Page), .Valid(Valid));

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   // Raw button levels recorded at every edge since reset; the debounced level flips
   // when the D samples that have reached the logic (two edges of sync delay) all
   // disagree with it. Samples from before reset read as released.
   bit           hist_n[$];
   bit           hist_p[$];
   bit           m_db_n, m_db_p;
   bit           m_evt_n, m_evt_p;
   bit           m_valid;
   bit [1:0]     m_page;
   bit [127:0]   m_cap;
   bit [31:0]    m_hex;

   function automatic bit samp(input int which, input int idx);
      if (idx < 0) return 1'b1;
      return (which == 0) ? hist_n[idx] : hist_p[idx];
   endfunction

   function automatic bit run_differs(input int which, input bit level);
      int e = (which == 0) ? hist_n.size() - 1 : hist_p.size() - 1;
      for (int k = e - 1 - D; k <= e - 2; k++)
         if (samp(which, k) == level) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      hist_n.delete(); hist_p.delete();
      m_db_n = 1; m_db_p = 1; m_evt_n = 0; m_evt_p = 0;
      m_valid = 0; m_page = 0; m_cap = '0; m_hex = '0;
   endfunction

   function automatic void model_edge();
      bit [31:0] hn;
      bit fn, fp;
      hn = 32'(m_cap >> (32 * (3 - int'(m_page))));
      if (Load) begin
         m_cap = Data_In; m_page = 0; m_valid = 1;
      end else if (m_valid) begin
         m_page = 2'((int'(m_page) + int'(m_evt_n) - int'(m_evt_p) + 4) % 4);
      end
      hist_n.push_back(Btn_Next_n);
      hist_p.push_back(Btn_Prev_n);
      fn = run_differs(0, m_db_n);
      fp = run_differs(1, m_db_p);
      m_evt_n = fn && m_db_n;
      m_evt_p = fp && m_db_p;
      if (fn) m_db_n = ~m_db_n;
      if (fp) m_db_p = ~m_db_p;
      m_hex = hn;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic hold_btns(input bit nx, input bit pv, input int cycles);
      Btn_Next_n = ~nx;
      Btn_Prev_n = ~pv;
      repeat (cycles) step();
      Btn_Next_n = 1'b1;
      Btn_Prev_n = 1'b1;
   endtask

   task automatic settle();
      repeat (D + 5) step();
   endtask

   task automatic do_load(input logic [127:0] d);
      Data_In = d;
      Load    = 1'b1;
      step();
      Load    = 1'b0;
   endtask

   task automatic pulse_reset();
      Reset_n = 1'b0;
      model_reset();
      #2;
      Reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Reset_n = 1'b0; Load = 1'b0; Data_In = '0; Btn_Next_n = 1'b1; Btn_Prev_n = 1'b1;
      model_reset();
      #12;
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL reset_page: got %0d want 0", Page); end
      n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", Valid); end
      n_checks++; if (Hex_Nibbles !== 32'h0) begin n_fail++; $display("FAIL reset_hex: got %h want 0", Hex_Nibbles); end
      @(negedge Clk);
      Reset_n = 1'b1;
      repeat (3) step();
      n_checks++; if (Hex_Nibbles !== m_hex || Valid !== m_valid) begin n_fail++; $display("FAIL post_reset_idle: got %h/%0b want %h/%0b", Hex_Nibbles, Valid, m_hex, m_valid); end
   endtask

   task automatic test_load();
      do_load(K);
      n_checks++; if (Valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %0b want 1", Valid); end
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL load_page: got %0d want 0", Page); end
      n_checks++; if (Hex_Nibbles !== 32'h0) begin n_fail++; $display("FAIL load_hex_lag: got %h want 0", Hex_Nibbles); end
      step();
      n_checks++; if (Hex_Nibbles !== 32'h01234567) begin n_fail++; $display("FAIL load_hex: got %h want 01234567", Hex_Nibbles); end
   endtask

   task automatic test_next();
      Btn_Next_n = 1'b0;
      repeat (6) step();   // edges 0..5
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL next_early: got %0d want 0", Page); end
      step();              // edge 6
      n_checks++; if (Page !== 2'd1) begin n_fail++; $display("FAIL next_page_edge6: got %0d want 1", Page); end
      n_checks++; if (Hex_Nibbles !== 32'h01234567) begin n_fail++; $display("FAIL next_hex_lag: got %h want 01234567", Hex_Nibbles); end
      step();              // edge 7
      n_checks++; if (Hex_Nibbles !== 32'h89ABCDEF) begin n_fail++; $display("FAIL next_hex_edge7: got %h want 89abcdef", Hex_Nibbles); end
      repeat (2) step();
      Btn_Next_n = 1'b1;
      settle();
      n_checks++; if (Page !== 2'd1) begin n_fail++; $display("FAIL next_no_repeat: got %0d want 1", Page); end
      hold_btns(1, 0, 6); settle();
      hold_btns(1, 0, 6); settle();
      n_checks++; if (Page !== 2'd3) begin n_fail++; $display("FAIL next_page3: got %0d want 3", Page); end
      n_checks++; if (Hex_Nibbles !== 32'h76543210) begin n_fail++; $display("FAIL next_hex3: got %h want 76543210", Hex_Nibbles); end
      hold_btns(1, 0, 6); settle();
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL next_wrap: got %0d want 0", Page); end
      n_checks++; if (Hex_Nibbles !== 32'h01234567) begin n_fail++; $display("FAIL next_wrap_hex: got %h want 01234567", Hex_Nibbles); end
   endtask

   task automatic test_prev_glitch();
      hold_btns(0, 1, 6); settle();
      n_checks++; if (Page !== 2'd3) begin n_fail++; $display("FAIL prev_wrap: got %0d want 3", Page); end
      n_checks++; if (Hex_Nibbles !== 32'h76543210) begin n_fail++; $display("FAIL prev_hex: got %h want 76543210", Hex_Nibbles); end
      hold_btns(1, 0, 3); settle();
      n_checks++; if (Page !== 2'd3) begin n_fail++; $display("FAIL glitch_next: got %0d want 3", Page); end
      hold_btns(0, 1, 3); settle();
      n_checks++; if (Page !== 2'd3) begin n_fail++; $display("FAIL glitch_prev: got %0d want 3", Page); end
      hold_btns(1, 0, 4); settle();   // exactly D cycles low is a real press
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL min_press: got %0d want 0", Page); end
   endtask

   task automatic test_both();
      hold_btns(1, 0, 6); settle();   // page 1
      Btn_Next_n = 1'b0; Btn_Prev_n = 1'b0;
      repeat (7) step();
      n_checks++; if (Page !== 2'd1) begin n_fail++; $display("FAIL both_edge6: got %0d want 1", Page); end
      Btn_Next_n = 1'b1; Btn_Prev_n = 1'b1;
      settle();
      n_checks++; if (Page !== 2'd1 || Page !== m_page) begin n_fail++; $display("FAIL both_settled: got %0d want 1", Page); end
   endtask

   task automatic test_no_valid();
      pulse_reset();
      hold_btns(1, 0, 6); settle();
      hold_btns(0, 1, 6); settle();
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL novalid_page: got %0d want 0", Page); end
      n_checks++; if (Hex_Nibbles !== 32'h0) begin n_fail++; $display("FAIL novalid_hex: got %h want 0", Hex_Nibbles); end
      n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL novalid_valid: got %0b want 0", Valid); end
   endtask

   task automatic test_load_priority();
      do_load(K);
      hold_btns(1, 0, 6); settle();
      hold_btns(1, 0, 6); settle();
      n_checks++; if (Page !== 2'd2) begin n_fail++; $display("FAIL prio_setup: got %0d want 2", Page); end
      Btn_Next_n = 1'b0;
      repeat (6) step();              // edges 0..5
      Data_In = {128{1'b1}};
      Load    = 1'b1;
      step();                         // edge 6: press event and Load together
      Load    = 1'b0;
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL prio_page: got %0d want 0", Page); end
      step();
      n_checks++; if (Hex_Nibbles !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL prio_hex: got %h want ffffffff", Hex_Nibbles); end
      repeat (2) step();
      Btn_Next_n = 1'b1;
      settle();
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL prio_no_late_step: got %0d want 0", Page); end
   endtask

   task automatic test_reset_mid();
      do_load(K);
      hold_btns(1, 0, 6); settle();
      hold_btns(1, 0, 6); settle();
      n_checks++; if (Hex_Nibbles !== 32'hFEDCBA98) begin n_fail++; $display("FAIL mid_setup_hex: got %h want fedcba98", Hex_Nibbles); end
      Btn_Next_n = 1'b0;
      repeat (3) step();
      #3;
      Reset_n = 1'b0;
      model_reset();
      Btn_Next_n = 1'b1;
      #1;
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL mid_page: got %0d want 0", Page); end
      n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", Valid); end
      n_checks++; if (Hex_Nibbles !== 32'h0) begin n_fail++; $display("FAIL mid_hex: got %h want 0", Hex_Nibbles); end
      #2;
      Reset_n = 1'b1;
      do_load(K);
      repeat (10) step();
      n_checks++; if (Page !== 2'd0) begin n_fail++; $display("FAIL mid_no_event: got %0d want 0", Page); end
      n_checks++; if (Hex_Nibbles !== 32'h01234567) begin n_fail++; $display("FAIL mid_reload_hex: got %h want 01234567", Hex_Nibbles); end
   endtask

   task automatic test_random();
      pulse_reset();
      for (int seg = 0; seg < 80; seg++) begin
         int len = $urandom_range(1, 9);
         Btn_Next_n = ($urandom_range(0, 2) != 0);
         Btn_Prev_n = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) Btn_Next_n = Btn_Prev_n;
         for (int c = 0; c < len; c++) begin
            Load = ($urandom_range(0, 19) == 0);
            if (Load) Data_In = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            Load = 1'b0;
            n_checks++;
            if (Page !== m_page || Hex_Nibbles !== m_hex || Valid !== m_valid) begin
               n_fail++;
               $display("FAIL random seg%0d: got page=%0d hex=%h valid=%0b want page=%0d hex=%h valid=%0b",
                        seg, Page, Hex_Nibbles, Valid, m_page, m_hex, m_valid);
            end
         end
      end
      Btn_Next_n = 1'b1; Btn_Prev_n = 1'b1;
      settle();
      n_checks++;
      if (Page !== m_page || Hex_Nibbles !== m_hex) begin
         n_fail++;
         $display("FAIL random_final: got page=%0d hex=%h want page=%0d hex=%h", Page, Hex_Nibbles, m_page, m_hex);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_next();
      test_prev_glitch();
      test_both();
      test_no_valid();
      test_load_priority();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
